panda_alu_arbiter: RTL and testbench

- Shares one combinational panda_alu instance between NumReq requesters, for example the execute stage and a future address/branch helper.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- The ALU result is captured into a single response register and returned on a valid/ready handshake tagged with the requester index.
- The block drives the ALU ports and receives its result. The ALU itself is instantiated alongside it.

---
 rtl/panda_alu_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_panda_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_alu_arbiter.sv
// Round-robin arbiter that lets NumReq requesters share one combinational
// panda_alu. The ALU result is captured into a single response register,
// which is returned on a valid/ready handshake tagged with the requester index.
// The operator package and the ALU itself are kept in this file so the
// arbiter is self-contained.

package panda_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_operator_e;

endpackage

// Combinational integer ALU: one result per operator.
// Shift operators use the low log2(Width) bits of operand B as the shift amount.
module panda_alu
  import panda_alu_pkg::*;
#(
  parameter int Width = 32
) (
  input  alu_operator_e    operator_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  output logic [Width-1:0] result_o
);

  localparam int ShW = $clog2(Width);

  logic [ShW-1:0] shamt;

  assign shamt = operand_b_i[ShW-1:0];

  // Operator decode; unknown encodings return zero.
  always_comb begin
    result_o = '0;
    case (operator_i)
      ALU_ADD:  result_o = operand_a_i + operand_b_i;
      ALU_SUB:  result_o = operand_a_i - operand_b_i;
      ALU_AND:  result_o = operand_a_i & operand_b_i;
      ALU_OR:   result_o = operand_a_i | operand_b_i;
      ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
      ALU_SLL:  result_o = operand_a_i << shamt;
      ALU_SRL:  result_o = operand_a_i >> shamt;
      ALU_SRA:  result_o = $signed(operand_a_i) >>> shamt;
      ALU_SLT:  result_o = {{(Width-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      ALU_SLTU: result_o = {{(Width-1){1'b0}}, operand_a_i < operand_b_i};
      default:  result_o = '0;
    endcase
  end

endmodule

// Arbiter in front of a shared panda_alu.
module panda_alu_arbiter
  import panda_alu_pkg::*;
#(
  parameter int Width  = 32,
  parameter int NumReq = 2,
  parameter int IdW    = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic          [NumReq-1:0]            req_valid_i,
  output logic          [NumReq-1:0]            req_ready_o,
  input  alu_operator_e [NumReq-1:0]            req_operator_i,
  input  logic          [NumReq-1:0][Width-1:0] req_operand_a_i,
  input  logic          [NumReq-1:0][Width-1:0] req_operand_b_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic          [IdW-1:0]          rsp_id_o,
  output logic          [Width-1:0]        rsp_result_o,
  output alu_operator_e                    alu_operator_o,
  output logic          [Width-1:0]        alu_operand_a_o,
  output logic          [Width-1:0]        alu_operand_b_o,
  input  logic          [Width-1:0]        alu_result_i
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  state_e         state_q;
  logic [IdW-1:0] ptr_q;
  logic           can_issue;
  logic           grant_valid;
  logic [IdW-1:0] grant_idx;
  logic [IdW:0]   cand_sum;
  logic [IdW-1:0] cand;

  // A new op may start when the response register is empty or draining this cycle.
  // Reset blocks every request handshake in the reset cycle.
  assign can_issue = !rst_i && ((state_q == EMPTY) || rsp_ready_i);

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    if (can_issue) begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        cand_sum = {1'b0, ptr_q} + (IdW+1)'(k);
        if (cand_sum >= (IdW+1)'(NumReq)) begin
          cand_sum = cand_sum - (IdW+1)'(NumReq);
        end
        cand = cand_sum[IdW-1:0];
        if (!grant_valid && req_valid_i[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // One-hot ready on the granted requester.
  always_comb begin
    req_ready_o = '0;
    if (grant_valid) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Steer the granted requester's op to the ALU; idle bus is all zeros.
  always_comb begin
    alu_operator_o  = alu_operator_e'('0);
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    if (grant_valid) begin
      alu_operator_o  = req_operator_i[grant_idx];
      alu_operand_a_o = req_operand_a_i[grant_idx];
      alu_operand_b_o = req_operand_b_i[grant_idx];
    end
  end

  // Response register FSM, round-robin pointer and result capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      ptr_q        <= '0;
    end else begin
      if (grant_valid) begin
        rsp_id_o     <= grant_idx;
        rsp_result_o <= alu_result_i;
        if (grant_idx == IdW'(NumReq - 1)) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= grant_idx + IdW'(1);
        end
      end
      case (state_q)
        EMPTY: begin
          if (grant_valid) begin
            state_q     <= FULL;
            rsp_valid_o <= 1'b1;
          end
        end
        FULL: begin
          if (rsp_ready_i && !grant_valid) begin
            state_q     <= EMPTY;
            rsp_valid_o <= 1'b0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_panda_alu_arbiter.sv
// Bench for panda_alu_arbiter: two instances (NumReq=2 and NumReq=3) share
// one stimulus. Each has its own cycle model of the arbiter; expected
// responses are pushed to a queue when a grant is predicted and are compared
// while the DUT holds its response.

module tb_panda_alu_arbiter;
  import panda_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic          [2:0]       req_valid;
  alu_operator_e [2:0]       req_op;
  logic          [2:0][31:0] req_a;
  logic          [2:0][31:0] req_b;
  logic                   rsp_ready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input alu_operator_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_tb
    localparam int N  = 2 + d;
    localparam int IW = $clog2(N);

    logic          [N-1:0]  req_ready;
    logic                   rsp_valid;
    logic          [IW-1:0] rsp_id;
    logic          [31:0]   rsp_result;
    alu_operator_e          alu_op;
    logic          [31:0]   alu_a;
    logic          [31:0]   alu_b;
    logic          [31:0]   alu_res;

    panda_alu_arbiter #(
      .Width (32),
      .NumReq(N)
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid[N-1:0]),
      .req_ready_o    (req_ready),
      .req_operator_i (req_op[N-1:0]),
      .req_operand_a_i(req_a[N-1:0]),
      .req_operand_b_i(req_b[N-1:0]),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_id_o       (rsp_id),
      .rsp_result_o   (rsp_result),
      .alu_operator_o (alu_op),
      .alu_operand_a_o(alu_a),
      .alu_operand_b_o(alu_b),
      .alu_result_i   (alu_res)
    );

    panda_alu #(
      .Width(32)
    ) u_alu (
      .operator_i (alu_op),
      .operand_a_i(alu_a),
      .operand_b_i(alu_b),
      .result_o   (alu_res)
    );

    int unsigned m_ptr = 0;
    bit          m_full = 1'b0;
    bit          m_after_rst = 1'b0;
    int unsigned q_id[$];
    logic [31:0] q_res[$];

    // Model and compare once per cycle, mid-period while inputs are stable.
    always @(negedge clk) begin
      bit          gv;
      int unsigned g;
      int unsigned idx;
      logic [N-1:0] exp_ready;
      gv = 1'b0;
      g  = 0;
      if (!rst && (!m_full || rsp_ready)) begin
        for (int unsigned k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!gv && req_valid[idx]) begin
            gv = 1'b1;
            g  = idx;
          end
        end
      end
      exp_ready = '0;
      if (gv) exp_ready[g] = 1'b1;

      check_eq($sformatf("n%0d_req_ready", N), 32'(req_ready), 32'(exp_ready));
      check_eq($sformatf("n%0d_rsp_valid", N), 32'(rsp_valid), 32'(m_full));
      if (m_after_rst) begin
        check_eq($sformatf("n%0d_rst_id", N), 32'(rsp_id), 32'd0);
        check_eq($sformatf("n%0d_rst_result", N), rsp_result, 32'd0);
      end
      if (m_full) begin
        if (q_id.size() == 0) begin
          check_eq($sformatf("n%0d_sb_empty", N), 32'd0, 32'd1);
        end else begin
          check_eq($sformatf("n%0d_rsp_id", N), 32'(rsp_id), q_id[0]);
          check_eq($sformatf("n%0d_rsp_result", N), rsp_result, q_res[0]);
        end
      end
      if (gv) begin
        check_eq($sformatf("n%0d_alu_op", N), 32'(alu_op), 32'(req_op[g]));
        check_eq($sformatf("n%0d_alu_a", N), alu_a, req_a[g]);
        check_eq($sformatf("n%0d_alu_b", N), alu_b, req_b[g]);
      end else begin
        check_eq($sformatf("n%0d_alu_idle", N), 32'(alu_op) | alu_a | alu_b, 32'd0);
      end

      if (rst) begin
        m_full      = 1'b0;
        m_ptr       = 0;
        m_after_rst = 1'b1;
        q_id.delete();
        q_res.delete();
      end else begin
        m_after_rst = 1'b0;
        if (m_full && rsp_ready && q_id.size() != 0) begin
          q_id.delete(0);
          q_res.delete(0);
        end
        if (gv) begin
          q_id.push_back(g);
          q_res.push_back(alu_ref(req_op[g], req_a[g], req_b[g]));
          m_ptr = (g + 1) % N;
        end
        m_full = gv || (m_full && !rsp_ready);
      end
    end
  end

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int unsigned r, input alu_operator_e op, input int a, input int b);
    req_op[r] = op;
    req_a[r]  = 32'(a);
    req_b[r]  = 32'(b);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = {ALU_ADD, ALU_ADD, ALU_ADD};
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);

    // Single request: 30 + 3.
    set_req(0, ALU_ADD, 30, 3);
    req_valid = 3'b001;
    step(1);
    req_valid = 3'b000;
    check_eq("single_valid", 32'(g_tb[0].rsp_valid), 32'd1);
    check_eq("single_result", g_tb[0].rsp_result, 32'd33);
    step(2);

    // Contention: both valid every cycle.
    set_req(0, ALU_SUB, 30, 50);
    set_req(1, ALU_ADD, -62, 5);
    req_valid = 3'b011;
    step(6);
    req_valid = 3'b000;
    step(2);

    // Backpressure: hold a 33 result while req1 waits.
    set_req(0, ALU_ADD, 30, 3);
    set_req(1, ALU_ADD, -35, -97);
    rsp_ready = 1'b0;
    req_valid = 3'b001;
    step(1);
    req_valid = 3'b010;
    step(4);
    check_eq("bp_held_result", g_tb[0].rsp_result, 32'd33);
    rsp_ready = 1'b1;
    step(1);
    req_valid = 3'b000;
    check_eq("bp_release_result", g_tb[0].rsp_result, 32'hFFFF_FF7C);
    check_eq("bp_release_id", 32'(g_tb[0].rsp_id), 32'd1);
    step(2);

    // Wrap-around: move pointer to 2 (NumReq=3), then only req0.
    set_req(2, ALU_SUB, 7, 9);
    req_valid = 3'b010;
    step(1);
    req_valid = 3'b001;
    step(1);
    req_valid = 3'b110;
    step(2);
    req_valid = 3'b000;
    step(2);

    // Reset while holding -134 with requesters valid.
    set_req(0, ALU_ADD, -100, -34);
    rsp_ready = 1'b0;
    req_valid = 3'b001;
    step(1);
    req_valid = 3'b011;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("rst_valid", 32'(g_tb[0].rsp_valid), 32'd0);
    check_eq("rst_result", g_tb[0].rsp_result, 32'd0);
    rsp_ready = 1'b1;
    step(1);
    check_eq("post_rst_id", 32'(g_tb[0].rsp_id), 32'd0);
    req_valid = 3'b000;
    step(2);

    // Operator sweep through alternating requesters.
    for (int unsigned o = 0; o < 10; o++) begin
      for (int unsigned p = 0; p < 2; p++) begin
        int unsigned r;
        r = (2 * o + p) % 2;
        if (p == 0) set_req(r, alu_operator_e'(o), -134, -90);
        else        set_req(r, alu_operator_e'(o), -12, -12);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        step(1);
      end
    end
    req_valid = 3'b000;
    step(2);

    // Random valid/backpressure with data held constant.
    set_req(0, ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
    set_req(1, ALU_SLTU, 5, -1);
    set_req(2, ALU_SRA, -256, 4);
    for (int unsigned i = 0; i < 300; i++) begin
      req_valid = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req_valid = 3'b000;
    rsp_ready = 1'b1;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
